pxs_stream_source: RTL and testbench

Head-of-chain PixelStream source: generates the 640x480@60 VGA timing and drives the 26-bit RGBStr bus (HS, VS, XC, YC, Active, RGB) consumed by every overlay block downstream. It supplies a selectable test-pattern background so overlays such as the bouncing-sprite block can be exercised without an external video source. It runs on the pixel clock and is the only block in the chain that owns the raster counters.

---
 rtl/pxs_stream_source_pkg.sv | 40 ++++
 rtl/pxs_stream_source_pattern_gen.sv | 53 +++++
 rtl/pxs_stream_source.sv | 124 ++++++++++++
 tb/tb_pxs_stream_source.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pxs_stream_source_pkg.sv
// Shared PixelStream definitions: default 640x480@60 timing, pattern-mode
// encodings and the 26-bit RGBStr bus layout used by sources and overlays.
package pxs_stream_source_pkg;

  localparam int unsigned PXS_H_VISIBLE = 640;
  localparam int unsigned PXS_H_FP      = 16;
  localparam int unsigned PXS_H_SYNC    = 96;
  localparam int unsigned PXS_H_BP      = 48;
  localparam int unsigned PXS_V_VISIBLE = 480;
  localparam int unsigned PXS_V_FP      = 10;
  localparam int unsigned PXS_V_SYNC    = 2;
  localparam int unsigned PXS_V_BP      = 33;

  typedef enum logic [1:0] {
    PXS_MODE_SOLID  = 2'd0,
    PXS_MODE_BARS   = 2'd1,
    PXS_MODE_CHECK  = 2'd2,
    PXS_MODE_SCROLL = 2'd3
  } pxs_mode_t;

  // RGBStr bus, MSB first: HS, VS, XC, YC, Active, RGB.
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [9:0] xc;
    logic [9:0] yc;
    logic       active;
    logic [2:0] rgb;
  } pxs_bus_t;

  // Bus value while idle/reset: syncs deasserted, everything else zero.
  function automatic pxs_bus_t pxs_idle_bus(input logic sync_pol);
    pxs_bus_t b;
    b        = '0;
    b.hs     = ~sync_pol;
    b.vs     = ~sync_pol;
    return b;
  endfunction

endpackage

// File: rtl/pxs_stream_source_pattern_gen.sv
// pxs_pattern_gen: combinational test-pattern colour generator.
//   h_cnt, v_cnt : raster position (10 bit each)
//   mode         : pattern select (solid, bars, checkerboard, scrolling bars)
//   frame_cnt    : frames completed, drives the scroll offset
//   rgb          : 3-bit colour (caller gates it with Active)
module pxs_pattern_gen
  import pxs_stream_source_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = PXS_H_VISIBLE,
  parameter int unsigned BAR_W      = 80,
  parameter int unsigned CHECK_LOG2 = 5,
  parameter logic [2:0]  SOLID_RGB  = 3'b101
) (
  input  logic [9:0] h_cnt,
  input  logic [9:0] v_cnt,
  input  pxs_mode_t  mode,
  input  logic [7:0] frame_cnt,
  output logic [2:0] rgb
);

  localparam logic [10:0] HV11 = 11'(H_VISIBLE);
  localparam logic [10:0] BW11 = 11'(BAR_W);

  // Bars run white (7) at the left down to black (0); index saturates at 7.
  function automatic logic [2:0] bar_colour(input logic [10:0] col);
    logic [10:0] idx;
    idx = col / BW11;
    if (idx > 11'd7) return 3'd0;
    return 3'(11'd7 - idx);
  endfunction

  logic [10:0] col_sum;
  logic [10:0] scroll_col;
  logic        chk_bit;

  // Offset is at most 510 and h_cnt < H_VISIBLE when visible, so one
  // conditional subtract is enough for the modulo.
  assign col_sum    = {1'b0, h_cnt} + {2'b0, frame_cnt, 1'b0};
  assign scroll_col = (col_sum >= HV11) ? (col_sum - HV11) : col_sum;
  assign chk_bit    = |(((h_cnt ^ v_cnt) >> CHECK_LOG2) & 10'd1);

  always_comb begin
    rgb = '0;
    unique case (mode)
      PXS_MODE_SOLID:  rgb = SOLID_RGB;
      PXS_MODE_BARS:   rgb = bar_colour({1'b0, h_cnt});
      PXS_MODE_CHECK:  rgb = chk_bit ? 3'b111 : 3'b000;
      PXS_MODE_SCROLL: rgb = bar_colour(scroll_col);
      default:         rgb = '0;
    endcase
  end

endmodule

// File: rtl/pxs_stream_source.sv
// pxs_stream_source: head-of-chain PixelStream source. Owns the raster
// counters, decodes VGA sync/active and registers the RGBStr bus.
//   px_clk        : pixel clock
//   reset_n       : asynchronous active-low reset
//   mode_i        : pattern select, taken at frame start only
//   RGBStr_o      : 26-bit PixelStream bus (see pxs_bus_t)
//   frame_start_o : one-cycle pulse on the XC=0, YC=0 beat
//   frame_cnt_o   : frames completed since reset (8-bit wrap)
module pxs_stream_source
  import pxs_stream_source_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = PXS_H_VISIBLE,
  parameter int unsigned H_FP       = PXS_H_FP,
  parameter int unsigned H_SYNC     = PXS_H_SYNC,
  parameter int unsigned H_BP       = PXS_H_BP,
  parameter int unsigned V_VISIBLE  = PXS_V_VISIBLE,
  parameter int unsigned V_FP       = PXS_V_FP,
  parameter int unsigned V_SYNC     = PXS_V_SYNC,
  parameter int unsigned V_BP       = PXS_V_BP,
  parameter logic        SYNC_POL   = 1'b0,
  parameter int unsigned BAR_W      = 80,
  parameter int unsigned CHECK_LOG2 = 5,
  parameter logic [2:0]  SOLID_RGB  = 3'b101
) (
  input  logic        px_clk,
  input  logic        reset_n,
  input  logic [1:0]  mode_i,
  output logic [25:0] RGBStr_o,
  output logic        frame_start_o,
  output logic [7:0]  frame_cnt_o
);

  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_S = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_E = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_S = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_E = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [7:0] frame_cnt;
  pxs_mode_t  mode_q;
  pxs_mode_t  mode_eff;
  logic       h_last;
  logic       v_last;
  logic       frame_origin;
  logic       active;
  logic       hs_on;
  logic       vs_on;
  logic [2:0] pat_rgb;
  pxs_bus_t   bus_d;
  pxs_bus_t   bus_q;

  assign h_last       = (h_cnt == H_LAST);
  assign v_last       = (v_cnt == V_LAST);
  assign frame_origin = (h_cnt == '0) && (v_cnt == '0);

  // The origin beat itself must already use the newly sampled mode, so
  // mode_i bypasses mode_q while it is being captured.
  assign mode_eff = frame_origin ? pxs_mode_t'(mode_i) : mode_q;

  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
      mode_q    <= PXS_MODE_SOLID;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + 10'd1;
      if (h_last) begin
        v_cnt <= v_last ? '0 : v_cnt + 10'd1;
        if (v_last) frame_cnt <= frame_cnt + 8'd1;
      end
      if (frame_origin) mode_q <= pxs_mode_t'(mode_i);
    end
  end

  assign active = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_on  = (h_cnt >= H_SYNC_S) && (h_cnt < H_SYNC_E);
  assign vs_on  = (v_cnt >= V_SYNC_S) && (v_cnt < V_SYNC_E);

  pxs_pattern_gen #(
    .H_VISIBLE  (H_VISIBLE),
    .BAR_W      (BAR_W),
    .CHECK_LOG2 (CHECK_LOG2),
    .SOLID_RGB  (SOLID_RGB)
  ) u_pattern (
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .mode      (mode_eff),
    .frame_cnt (frame_cnt),
    .rgb       (pat_rgb)
  );

  always_comb begin
    bus_d        = '0;
    bus_d.hs     = hs_on ? SYNC_POL : ~SYNC_POL;
    bus_d.vs     = vs_on ? SYNC_POL : ~SYNC_POL;
    bus_d.xc     = h_cnt;
    bus_d.yc     = v_cnt;
    bus_d.active = active;
    bus_d.rgb    = active ? pat_rgb : 3'b000;
  end

  // frame_cnt lags by one beat so frame_cnt_o changes together with the
  // origin beat it belongs to.
  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_q         <= pxs_idle_bus(SYNC_POL);
      frame_start_o <= 1'b0;
      frame_cnt_o   <= '0;
    end else begin
      bus_q         <= bus_d;
      frame_start_o <= frame_origin;
      frame_cnt_o   <= frame_cnt;
    end
  end

  assign RGBStr_o = bus_q;

endmodule

// File: tb/tb_pxs_stream_source.sv
// Directed bench for pxs_stream_source with full horizontal timing and a
// shortened vertical frame (4 visible lines, 8 total) to keep runs short.
module tb_pxs_stream_source;
  import pxs_stream_source_pkg::*;

  localparam int unsigned TB_V_VISIBLE = 4;
  localparam int unsigned TB_V_FP      = 1;
  localparam int unsigned TB_V_SYNC    = 2;
  localparam int unsigned TB_V_BP      = 1;
  localparam int unsigned LINE         = 800;
  localparam int unsigned FRAME        = LINE * 8;
  localparam int unsigned LIM          = FRAME + 4;

  logic        px_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic [25:0] RGBStr_o;
  logic        frame_start_o;
  logic [7:0]  frame_cnt_o;
  pxs_bus_t    bus;

  assign bus = RGBStr_o;

  pxs_stream_source #(
    .V_VISIBLE (TB_V_VISIBLE),
    .V_FP      (TB_V_FP),
    .V_SYNC    (TB_V_SYNC),
    .V_BP      (TB_V_BP)
  ) dut (
    .px_clk        (px_clk),
    .reset_n       (reset_n),
    .mode_i        (mode_i),
    .RGBStr_o      (RGBStr_o),
    .frame_start_o (frame_start_o),
    .frame_cnt_o   (frame_cnt_o)
  );

  always #5 px_clk = ~px_clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    logic [1:0]  mode;
    int unsigned x;
    int unsigned y;
    logic [2:0]  rgb;
    logic        act;
  } vec_t;

  vec_t vecs [20];

  int unsigned hs_len, act_len, vs_beats, end_beats;
  int          hs_start, act_start;
  logic [15:0] vs_mask;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait expired", name);
  endtask

  // Advances until the sampled beat is (x,y); the current beat counts.
  task automatic wait_beat(input int unsigned x, input int unsigned y);
    int unsigned n = 0;
    while (!(32'(bus.xc) == x && 32'(bus.yc) == y) && n < LIM) begin
      @(negedge px_clk);
      n++;
    end
    if (n >= LIM) timeout_fail($sformatf("beat_%0d_%0d", x, y));
  endtask

  task automatic wait_fs(output int unsigned n);
    n = 0;
    do begin
      @(negedge px_clk);
      n++;
    end while (!frame_start_o && n < LIM);
  endtask

  task automatic sample_stats();
    if (bus.yc == 10'd0) begin
      if (!bus.hs) begin
        if (hs_len == 0) hs_start = int'(bus.xc);
        hs_len++;
      end
      if (bus.active) begin
        if (act_len == 0) act_start = int'(bus.xc);
        act_len++;
      end
    end
    if (!bus.vs) begin
      vs_beats++;
      vs_mask[bus.yc[3:0]] = 1'b1;
    end
    if (bus.xc == 10'd639 && bus.yc == 10'd3 && bus.active) end_beats++;
  endtask

  initial begin
    int unsigned cnt;
    logic [1:0]  cur_mode;

    vecs[0]  = '{2'd0,  10, 0, 3'd5, 1'b1};
    vecs[1]  = '{2'd0, 650, 1, 3'd0, 1'b0};
    vecs[2]  = '{2'd0, 639, 3, 3'd5, 1'b1};
    vecs[3]  = '{2'd0,   0, 4, 3'd0, 1'b0};
    vecs[4]  = '{2'd1,   0, 0, 3'd7, 1'b1};
    vecs[5]  = '{2'd1,  79, 0, 3'd7, 1'b1};
    vecs[6]  = '{2'd1,  80, 0, 3'd6, 1'b1};
    vecs[7]  = '{2'd1, 639, 0, 3'd0, 1'b1};
    vecs[8]  = '{2'd1, 640, 0, 3'd0, 1'b0};
    vecs[9]  = '{2'd1, 159, 1, 3'd6, 1'b1};
    vecs[10] = '{2'd1, 160, 1, 3'd5, 1'b1};
    vecs[11] = '{2'd1, 400, 2, 3'd2, 1'b1};
    vecs[12] = '{2'd1, 560, 3, 3'd0, 1'b1};
    vecs[13] = '{2'd2,   0, 0, 3'd0, 1'b1};
    vecs[14] = '{2'd2,  31, 0, 3'd0, 1'b1};
    vecs[15] = '{2'd2,  32, 0, 3'd7, 1'b1};
    vecs[16] = '{2'd2,  63, 1, 3'd7, 1'b1};
    vecs[17] = '{2'd2,  64, 1, 3'd0, 1'b1};
    vecs[18] = '{2'd2, 100, 2, 3'd7, 1'b1};
    vecs[19] = '{2'd2, 700, 2, 3'd0, 1'b0};

    // Reset state
    repeat (2) @(negedge px_clk);
    check("rst_xc", 32'(bus.xc), 0);
    check("rst_yc", 32'(bus.yc), 0);
    check("rst_active", 32'(bus.active), 0);
    check("rst_rgb", 32'(bus.rgb), 0);
    check("rst_hs", 32'(bus.hs), 1);
    check("rst_vs", 32'(bus.vs), 1);
    check("rst_fs", 32'(frame_start_o), 0);
    check("rst_fcnt", 32'(frame_cnt_o), 0);

    reset_n = 1'b1;
    @(negedge px_clk);
    check("first_xc", 32'(bus.xc), 0);
    check("first_yc", 32'(bus.yc), 0);
    check("first_active", 32'(bus.active), 1);
    check("first_fs", 32'(frame_start_o), 1);
    check("first_fcnt", 32'(frame_cnt_o), 0);
    check("first_rgb", 32'(bus.rgb), 5);

    // Frame 0 timing statistics
    hs_len = 0; act_len = 0; vs_beats = 0; end_beats = 0;
    hs_start = -1; act_start = -1; vs_mask = '0;
    sample_stats();
    cnt = 0;
    while (cnt < LIM) begin
      @(negedge px_clk);
      cnt++;
      if (frame_start_o) break;
      sample_stats();
    end
    check("frame0_period", cnt, FRAME);
    check("frame0_fcnt", 32'(frame_cnt_o), 1);
    check("hs_len", hs_len, 96);
    check("hs_start", hs_start, 656);
    check("act_len", act_len, 640);
    check("act_start", act_start, 0);
    check("vs_mask", 32'(vs_mask), 32'h0060);
    check("vs_beats", vs_beats, 2 * LINE);
    check("end_beats", end_beats, 1);

    wait_fs(cnt);
    check("frame1_period", cnt, FRAME);
    check("frame1_fcnt", 32'(frame_cnt_o), 2);

    // Pattern table
    cur_mode = 2'd0;
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].mode != cur_mode) begin
        mode_i   = vecs[i].mode;
        cur_mode = vecs[i].mode;
        wait_fs(cnt);
        if (cnt >= LIM) timeout_fail("mode_fs");
      end
      wait_beat(vecs[i].x, vecs[i].y);
      check($sformatf("vec%0d_rgb", i), 32'(bus.rgb), 32'(vecs[i].rgb));
      check($sformatf("vec%0d_act", i), 32'(bus.active), 32'(vecs[i].act));
    end

    // Mode change mid-frame is deferred to the next frame
    mode_i = 2'd0;
    wait_fs(cnt);
    wait_beat(0, 1);
    mode_i = 2'd2;
    wait_beat(32, 2);
    check("defer_32_2", 32'(bus.rgb), 5);
    wait_beat(0, 3);
    check("defer_0_3", 32'(bus.rgb), 5);
    wait_beat(0, 0);
    check("next_0_0", 32'(bus.rgb), 0);
    wait_beat(32, 0);
    check("next_32_0", 32'(bus.rgb), 7);

    // Asynchronous reset mid-frame, then scrolling bars from a clean start
    wait_beat(300, 2);
    mode_i  = 2'd3;
    reset_n = 1'b0;
    #1;
    check("arst_xc", 32'(bus.xc), 0);
    check("arst_yc", 32'(bus.yc), 0);
    check("arst_active", 32'(bus.active), 0);
    check("arst_hs", 32'(bus.hs), 1);
    check("arst_fcnt", 32'(frame_cnt_o), 0);
    repeat (3) @(negedge px_clk);
    reset_n = 1'b1;
    @(negedge px_clk);
    check("rel_xc", 32'(bus.xc), 0);
    check("rel_yc", 32'(bus.yc), 0);
    check("rel_fs", 32'(frame_start_o), 1);
    check("rel_fcnt", 32'(frame_cnt_o), 0);
    check("scroll0_0", 32'(bus.rgb), 7);
    wait_beat(80, 0);
    check("scroll0_80", 32'(bus.rgb), 6);
    wait_fs(cnt);
    check("scroll1_fcnt", 32'(frame_cnt_o), 1);
    wait_beat(77, 0);
    check("scroll1_77", 32'(bus.rgb), 7);
    wait_beat(78, 0);
    check("scroll1_78", 32'(bus.rgb), 6);
    wait_fs(cnt);
    wait_beat(635, 0);
    check("scroll2_635", 32'(bus.rgb), 0);
    wait_beat(636, 0);
    check("scroll2_636", 32'(bus.rgb), 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
